cpu_run_ctrl: RTL and testbench

//  Run/step controller for the single-cycle CPU datapath. Issues the cpu_en

---
 rtl/cpu_ctrl_pkg.sv | 33 +++
 rtl/run_budget_cnt.sv | 35 +++
 rtl/cpu_run_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step controller: FSM states, command
// opcodes and stop causes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_STOPPED = 3'd3,
        ST_HALTED  = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_STOP  = 2'd1,
        OP_STEP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_HALT   = 3'd1,
        CAUSE_BREAK  = 3'd2,
        CAUSE_USER   = 3'd3,
        CAUSE_BUDGET = 3'd4,
        CAUSE_STEP   = 3'd5
    } stop_cause_e;

    function automatic logic is_stop_state(input run_state_e s);
        return (s == ST_STOPPED) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/run_budget_cnt.sv
// Remaining-cycle budget for a RUN session: loaded on RUN acceptance,
// decremented per executed cycle; a loaded value of zero means unlimited.
module run_budget_cnt #(
    parameter int CYC_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CYC_W-1:0] i_budget,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_unlimited
);

    logic [CYC_W-1:0] r_remaining;
    logic             r_unlimited;

    // Budget load has priority over decrement
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_remaining <= {CYC_W{1'b0}};
            r_unlimited <= 1'b0;
        end else if (i_load) begin
            r_remaining <= i_budget;
            r_unlimited <= (i_budget == {CYC_W{1'b0}});
        end else if (i_dec && !r_unlimited) begin
            r_remaining <= r_remaining - {{(CYC_W-1){1'b0}}, 1'b1};
        end
    end

    // High in the cycle whose decrement empties the budget
    assign o_zero      = i_dec && !r_unlimited && (r_remaining == {{(CYC_W-1){1'b0}}, 1'b1});
    assign o_unlimited = r_unlimited;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller issuing the datapath clock enable.
// Optional breakpoint comparator enabled by defining RUN_CTRL_BP_EN.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CYC_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd_op,
    output logic              o_cmd_ready,
    input  logic [CYC_W-1:0]  i_budget,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_halt,
    input  logic              i_bp_en,
    input  logic [ADDR_W-1:0] i_bp_addr,
    output logic              o_cpu_en,
    output logic [2:0]        o_state,
    output logic [2:0]        o_stop_cause,
    output logic [CYC_W-1:0]  o_cyc_cnt,
    output logic              o_done_pulse
);

    run_state_e       r_state;
    stop_cause_e      r_cause;
    logic             r_cmd_ready;
    logic             r_done;
    logic [CYC_W-1:0] r_cyc_cnt;

    run_state_e  w_state_nxt;
    stop_cause_e w_cause_nxt;
    logic        w_load;
    logic        w_set_skip;
    logic        w_clr_cnt;
    logic        w_cmd_acc;
    logic        w_active;
    logic        w_bp_hit;
    logic        w_cpu_en;
    logic        w_dec;
    logic        w_budget_zero;
    logic        w_unlimited;

    assign w_cmd_acc = i_cmd_valid && r_cmd_ready;
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_STEP);

`ifdef RUN_CTRL_BP_EN
    logic r_bp_skip;

    // Skip the breakpoint for the first cycle after a resume
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bp_skip <= 1'b0;
        end else if (w_set_skip) begin
            r_bp_skip <= 1'b1;
        end else if (w_active) begin
            r_bp_skip <= 1'b0;
        end
    end

    assign w_bp_hit = i_bp_en && (i_pc == i_bp_addr) && !r_bp_skip;
`else
    logic w_unused_bp;
    assign w_unused_bp = &{1'b0, i_bp_en, i_bp_addr, i_pc, w_set_skip};
    assign w_bp_hit    = 1'b0;
`endif

    assign w_cpu_en = w_active && !i_halt && !w_bp_hit;
    assign w_dec    = w_cpu_en && (r_state == ST_RUN) && !w_unlimited;

    run_budget_cnt #(.CYC_W(CYC_W)) u_budget (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_budget    (i_budget),
        .i_dec       (w_dec),
        .o_zero      (w_budget_zero),
        .o_unlimited (w_unlimited)
    );

    // Next-state and stop-cause selection; stop events in priority order
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_load      = 1'b0;
        w_set_skip  = 1'b0;
        w_clr_cnt   = 1'b0;
        case (r_state)
            ST_IDLE, ST_STOPPED: begin
                if (w_cmd_acc) begin
                    case (cmd_op_e'(i_cmd_op))
                        OP_RUN: begin
                            w_state_nxt = ST_RUN;
                            w_cause_nxt = CAUSE_NONE;
                            w_load      = 1'b1;
                            w_set_skip  = 1'b1;
                        end
                        OP_STEP: begin
                            w_state_nxt = ST_STEP;
                            w_set_skip  = 1'b1;
                        end
                        OP_CLEAR: begin
                            w_state_nxt = ST_IDLE;
                            w_cause_nxt = CAUSE_NONE;
                            w_clr_cnt   = 1'b1;
                        end
                        default: begin
                            w_state_nxt = r_state;
                        end
                    endcase
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_HALT;
                end else if (w_bp_hit) begin
                    w_state_nxt = ST_STOPPED;
                    w_cause_nxt = CAUSE_BREAK;
                end else if (w_cmd_acc && (cmd_op_e'(i_cmd_op) == OP_STOP)) begin
                    w_state_nxt = ST_STOPPED;
                    w_cause_nxt = CAUSE_USER;
                end else if (w_budget_zero) begin
                    w_state_nxt = ST_STOPPED;
                    w_cause_nxt = CAUSE_BUDGET;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    w_state_nxt = ST_HALTED;
                    w_cause_nxt = CAUSE_HALT;
                end else if (w_bp_hit) begin
                    w_state_nxt = ST_STOPPED;
                    w_cause_nxt = CAUSE_BREAK;
                end else begin
                    w_state_nxt = ST_STOPPED;
                    w_cause_nxt = CAUSE_STEP;
                end
            end
            ST_HALTED: begin
                if (w_cmd_acc && (cmd_op_e'(i_cmd_op) == OP_CLEAR)) begin
                    w_state_nxt = ST_IDLE;
                    w_cause_nxt = CAUSE_NONE;
                    w_clr_cnt   = 1'b1;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    // State, cause, handshake and completion-pulse registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cause     <= CAUSE_NONE;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_cmd_ready <= (w_state_nxt != ST_STEP);
            r_done      <= is_stop_state(w_state_nxt) && (w_state_nxt != r_state);
        end
    end

    // Executed-cycle counter, wraps naturally
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cyc_cnt <= {CYC_W{1'b0}};
        end else if (w_clr_cnt) begin
            r_cyc_cnt <= {CYC_W{1'b0}};
        end else if (w_cpu_en) begin
            r_cyc_cnt <= r_cyc_cnt + {{(CYC_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cpu_en     = w_cpu_en;
    assign o_cmd_ready  = r_cmd_ready;
    assign o_state      = r_state;
    assign o_stop_cause = r_cause;
    assign o_cyc_cnt    = r_cyc_cnt;
    assign o_done_pulse = r_done;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl; breakpoint expectations
// follow whether RUN_CTRL_BP_EN is defined.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd_op;
    logic        o_cmd_ready;
    logic [31:0] i_budget;
    logic [31:0] i_pc;
    logic        i_halt;
    logic        i_bp_en;
    logic [31:0] i_bp_addr;
    logic        o_cpu_en;
    logic [2:0]  o_state;
    logic [2:0]  o_stop_cause;
    logic [31:0] o_cyc_cnt;
    logic        o_done_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int n_exec;

`ifdef RUN_CTRL_BP_EN
    localparam int          EXP_N1 = 4;
    localparam logic [31:0] EXP_PC1 = 32'h10;
    localparam logic [2:0]  EXP_C1 = 3'd2;
    localparam logic [31:0] EXP_PC2 = 32'h1C;
    localparam logic [31:0] EXP_CYC3 = 32'd7;
`else
    localparam int          EXP_N1 = 6;
    localparam logic [31:0] EXP_PC1 = 32'h18;
    localparam logic [2:0]  EXP_C1 = 3'd4;
    localparam logic [31:0] EXP_PC2 = 32'h24;
    localparam logic [31:0] EXP_CYC3 = 32'd9;
`endif

    cpu_run_ctrl #(.ADDR_W(32), .CYC_W(32)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd_op     (i_cmd_op),
        .o_cmd_ready  (o_cmd_ready),
        .i_budget     (i_budget),
        .i_pc         (i_pc),
        .i_halt       (i_halt),
        .i_bp_en      (i_bp_en),
        .i_bp_addr    (i_bp_addr),
        .o_cpu_en     (o_cpu_en),
        .o_state      (o_state),
        .o_stop_cause (o_stop_cause),
        .o_cyc_cnt    (o_cyc_cnt),
        .o_done_pulse (o_done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the PC model advances by 4 on every enabled cycle
    task automatic tick();
        logic en_s;
        #1;
        en_s = o_cpu_en;
        @(posedge clk);
        #1;
        if (en_s) i_pc = i_pc + 32'd4;
        if (o_done_pulse) done_cnt++;
    endtask

    task automatic cmd(input logic [1:0] op);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_until_stop(input int max_cyc, output int n);
        n = 0;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (o_state != 3'd1) break;
            n += int'(o_cpu_en);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = 2'd0; i_budget = 32'd0;
        i_pc = 32'd0; i_halt = 1'b0; i_bp_en = 1'b0; i_bp_addr = 32'd0;
        #1 i_reset = 1'b1;
        #2;
        check("rst_state", o_state, 3'd0);
        check("rst_cpu_en", o_cpu_en, 1'b0);
        check("rst_ready", o_cmd_ready, 1'b1);
        check("rst_cause", o_stop_cause, 3'd0);
        check("rst_cyc", o_cyc_cnt, 32'd0);
        check("rst_done", o_done_pulse, 1'b0);
        @(negedge clk) i_reset = 1'b0;
        @(posedge clk); #1;

        // 1: unlimited run, halt after 20 executed cycles
        done_cnt = 0;
        i_budget = 32'd0;
        cmd(2'd0);
        check("t1_state_run", o_state, 3'd1);
        for (int i = 0; i < 20; i++) tick();
        i_halt = 1'b1;
        #1;
        check("t1_halt_blocks_en", o_cpu_en, 1'b0);
        tick();
        i_halt = 1'b0;
        check("t1_state", o_state, 3'd4);
        check("t1_cause", o_stop_cause, 3'd1);
        check("t1_cyc", o_cyc_cnt, 32'd20);
        tick();
        check("t1_done_once", done_cnt, 1);
        cmd(2'd3);
        check("t1_clear_state", o_state, 3'd0);

        // 2: budget exhaustion, then a second budgeted run
        i_budget = 32'd5;
        cmd(2'd0);
        run_until_stop(40, n_exec);
        check("t2_n5", n_exec, 5);
        check("t2_state", o_state, 3'd3);
        check("t2_cause", o_stop_cause, 3'd4);
        check("t2_done", o_done_pulse, 1'b1);
        i_budget = 32'd3;
        cmd(2'd0);
        run_until_stop(40, n_exec);
        check("t2_n3", n_exec, 3);
        check("t2_cyc8", o_cyc_cnt, 32'd8);

        // 3: breakpoint at 0x10 and resume through it
        cmd(2'd3);
        i_pc = 32'd0; i_bp_addr = 32'h10; i_bp_en = 1'b1; i_budget = 32'd6;
        cmd(2'd0);
        run_until_stop(40, n_exec);
        check("t3_n_first", n_exec, EXP_N1);
        check("t3_pc_first", i_pc, EXP_PC1);
        check("t3_cause_first", o_stop_cause, EXP_C1);
        check("t3_state_first", o_state, 3'd3);
        i_budget = 32'd3;
        cmd(2'd0);
        run_until_stop(40, n_exec);
        check("t3_n_resume", n_exec, 3);
        check("t3_pc_resume", i_pc, EXP_PC2);
        check("t3_cause_resume", o_stop_cause, 3'd4);
        check("t3_cyc", o_cyc_cnt, EXP_CYC3);
        i_bp_en = 1'b0;

        // 4: three single steps from IDLE
        cmd(2'd3);
        for (int s = 0; s < 3; s++) begin
            cmd(2'd2);
            #1;
            check("t4_state_step", o_state, 3'd2);
            check("t4_ready_low", o_cmd_ready, 1'b0);
            check("t4_en", o_cpu_en, 1'b1);
            tick();
            check("t4_state_stop", o_state, 3'd3);
            check("t4_cause", o_stop_cause, 3'd5);
            check("t4_done", o_done_pulse, 1'b1);
        end
        check("t4_cyc3", o_cyc_cnt, 32'd3);

        // 5a: user stop executes its acceptance cycle; STOP when stopped is ignored
        cmd(2'd3);
        i_budget = 32'd0;
        cmd(2'd0);
        tick(); tick();
        cmd(2'd1);
        check("t5a_state", o_state, 3'd3);
        check("t5a_cause", o_stop_cause, 3'd3);
        check("t5a_cyc", o_cyc_cnt, 32'd3);
        cmd(2'd1);
        check("t5a_ignored", o_state, 3'd3);

        // 5: STOP and halt together, halt wins
        cmd(2'd3);
        cmd(2'd0);
        tick(); tick();
        i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_halt = 1'b1;
        tick();
        i_cmd_valid = 1'b0; i_halt = 1'b0;
        check("t5_state", o_state, 3'd4);
        check("t5_cause", o_stop_cause, 3'd1);
        check("t5_cyc", o_cyc_cnt, 32'd2);
        cmd(2'd0);
        check("t5_run_ignored", o_state, 3'd4);
        cmd(2'd3);
        check("t5_clear_state", o_state, 3'd0);
        check("t5_clear_cyc", o_cyc_cnt, 32'd0);
        check("t5_clear_cause", o_stop_cause, 3'd0);

        // 6: asynchronous reset in the middle of a run
        cmd(2'd0);
        tick(); tick(); tick();
        #1;
        check("t6_en_before", o_cpu_en, 1'b1);
        i_reset = 1'b1;
        #1;
        check("t6_en", o_cpu_en, 1'b0);
        check("t6_state", o_state, 3'd0);
        check("t6_ready", o_cmd_ready, 1'b1);
        check("t6_cause", o_stop_cause, 3'd0);
        check("t6_cyc", o_cyc_cnt, 32'd0);
        check("t6_done", o_done_pulse, 1'b0);
        @(negedge clk) i_reset = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
